fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    localparam int unsigned DEFAULT_IW  = 32;
    localparam int unsigned INSTR_BYTES = DEFAULT_IW / 8;

    // Sequential PC step; arithmetic wraps modulo 2^64 and the caller
    // truncates to its own address width, so wrap-around falls out naturally.
    function automatic logic [63:0] next_seq_pc(input logic [63:0] pc, input int unsigned iw);
        return pc + 64'(iw / 8);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetched {pc, instr} entries with push, pop and flush.
// Pushing while full and popping while empty are ignored.
module fetch_fifo #(
    parameter int unsigned W     = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  storage_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [PW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign rdata_o = storage_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointer, occupancy and storage update; flush empties the queue but leaves stale data behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                storage_q[i] <= '0;
            end
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                storage_q[wrPtr_q] <= wdata_i;
                wrPtr_q            <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generation with exception/branch/sequential
// priority, a req/ack imem port that tolerates variable latency, and a
// small queue of {pc, instr} pairs feeding decode.
// Build option: define FETCH_BYPASS_EN to let a response arriving at an
// empty queue reach decode in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned    N        = 64,
    parameter int unsigned    IW       = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     PCSrc_F,
    input  logic [N-1:0]             PCBranch_F,
    input  logic                     EProc_F,
    input  logic [N-1:0]             EVAddr_F,
    output logic                     imem_req,
    output logic [N-1:0]             imem_addr_F,
    input  logic                     imem_ack,
    input  logic [IW-1:0]            imem_rdata,
    output logic                     dec_valid,
    output logic [IW-1:0]            dec_instr,
    output logic [N-1:0]             dec_pc,
    input  logic                     dec_ready,
    output logic [N-1:0]             NextPC_F,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned W = N + IW;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;
    logic [N-1:0] discardAddr_q;
    logic [N-1:0] discardAddr_d;

    logic         redirect;
    logic [N-1:0] target;
    logic [N-1:0] seqPc;
    logic         accept;
    logic         bypassHit;
    logic         bypassTake;
    logic         fifoPush;
    logic         fifoPop;
    logic         fifoEmpty;
    logic         fifoFull;
    logic [W-1:0] headData;

    assign redirect = EProc_F | PCSrc_F;
    assign target   = EProc_F ? EVAddr_F : PCBranch_F;
    assign seqPc    = N'(next_seq_pc(64'(pc_q), IW));

    // A response is kept only when it belongs to the live request and no redirect kills it.
    assign accept   = (state_q == REQ) && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypassHit  = accept && fifoEmpty;
    assign bypassTake = bypassHit && dec_ready;
`else
    assign bypassHit  = 1'b0;
    assign bypassTake = 1'b0;
`endif

    assign fifoPush = accept && !bypassTake;
    assign fifoPop  = dec_ready && !fifoEmpty && !redirect;

    fetch_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .flush_i (redirect),
        .wdata_i ({pc_q, imem_rdata}),
        .rdata_o (headData),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull),
        .count_o (fq_count)
    );

    // Decode sees the queue head, or the live response when it bypasses an empty queue.
    always_comb begin
        dec_valid = !fifoEmpty;
        dec_instr = headData[IW-1:0];
        dec_pc    = headData[W-1:IW];
        if (bypassHit) begin
            dec_valid = 1'b1;
            dec_instr = imem_rdata;
            dec_pc    = pc_q;
        end
    end

    // Next-state, next-PC and imem port drive; DISCARD keeps presenting the abandoned address until it is acked.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discardAddr_d = discardAddr_q;
        imem_req      = 1'b0;
        imem_addr_F   = pc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = target;
                end else if (!fifoFull) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req    = 1'b1;
                imem_addr_F = pc_q;
                if (imem_ack) begin
                    state_d = IDLE;
                    pc_d    = redirect ? target : seqPc;
                end else if (redirect) begin
                    state_d       = DISCARD;
                    discardAddr_d = pc_q;
                    pc_d          = target;
                end
            end
            DISCARD: begin
                imem_req    = 1'b1;
                imem_addr_F = discardAddr_q;
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign NextPC_F = pc_d;

    // State, PC and held discard address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            discardAddr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discardAddr_q <= discardAddr_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table from reset,
// hand-written wrap-around and reset-mid-request sequences, then random
// redirects, decode stalls and memory latency checked against a queue model.
module tb_fetch_queue;

    localparam int N     = 64;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          PCSrc_F;
    logic [N-1:0]  PCBranch_F;
    logic          EProc_F;
    logic [N-1:0]  EVAddr_F;
    logic          imem_req;
    logic [N-1:0]  imem_addr_F;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          dec_valid;
    logic [IW-1:0] dec_instr;
    logic [N-1:0]  dec_pc;
    logic          dec_ready;
    logic [N-1:0]  NextPC_F;
    logic [2:0]    fq_count;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        ps;
        logic [63:0] pb;
        logic        ep;
        logic [63:0] ev;
        logic        eReq;
        logic [63:0] eAddr;
        logic        eValid;
        logic [63:0] eDpc;
        int          eCnt;
        logic [63:0] eNext;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    vec_t   vecs[$];
    entry_t mQ[$];

    fetch_queue #(
        .N        (N),
        .IW       (IW),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc_F     (PCSrc_F),
        .PCBranch_F  (PCBranch_F),
        .EProc_F     (EProc_F),
        .EVAddr_F    (EVAddr_F),
        .imem_req    (imem_req),
        .imem_addr_F (imem_addr_F),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .NextPC_F    (NextPC_F),
        .fq_count    (fq_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a fixed function of the address.
    function automatic logic [31:0] memData(input logic [63:0] a);
        return a[31:0] ^ (a[63:32] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic a, input logic r, input logic ps,
                                 input logic [63:0] pb, input logic ep, input logic [63:0] ev);
        reset      = rst;
        imem_ack   = a;
        imem_rdata = a ? memData(imem_addr_F) : '0;
        dec_ready  = r;
        PCSrc_F    = ps;
        PCBranch_F = pb;
        EProc_F    = ep;
        EVAddr_F   = ev;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic eReq, input logic [63:0] eAddr,
                               input logic eValid, input logic [63:0] eDpc, input int eCnt,
                               input logic [63:0] eNext);
        check({tag, ".req"}, 64'(imem_req), 64'(eReq));
        if (eReq) check({tag, ".addr"}, imem_addr_F, eAddr);
        check({tag, ".valid"}, 64'(dec_valid), 64'(eValid));
        if (eValid) begin
            check({tag, ".dpc"}, dec_pc, eDpc);
            check({tag, ".instr"}, 64'(dec_instr), 64'(memData(eDpc)));
        end
        check({tag, ".count"}, 64'(fq_count), 64'(eCnt));
        check({tag, ".nextpc"}, NextPC_F, eNext);
    endtask

    task automatic runCycle(input string tag, input logic rst, input logic a, input logic r,
                            input logic ps, input logic [63:0] pb, input logic ep, input logic [63:0] ev,
                            input logic eReq, input logic [63:0] eAddr, input logic eValid,
                            input logic [63:0] eDpc, input int eCnt, input logic [63:0] eNext);
        @(negedge clk);
        applyStimulus(rst, a, r, ps, pb, ep, ev);
        checkOutput(tag, eReq, eAddr, eValid, eDpc, eCnt, eNext);
    endtask

    task automatic addVec(input logic a, input logic r, input logic ps, input logic [63:0] pb,
                          input logic ep, input logic [63:0] ev, input logic eReq, input logic [63:0] eAddr,
                          input logic eValid, input logic [63:0] eDpc, input int eCnt, input logic [63:0] eNext);
        vec_t v;
        v = '{a, r, ps, pb, ep, ev, eReq, eAddr, eValid, eDpc, eCnt, eNext};
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] mPc;
        logic [63:0] mAddr;
        bit          mBusy;
        bit          mStale;
        int          lat;
        logic        a, r, ps, ep, redirect, accept, take, bypassHit, eValid;
        logic [63:0] pb, ev, tgt, nextPc, eDpc;
        int          sizeBefore;

        // Reset-to-empty fill, drain one, stale-redirect discard, double redirect, bypass candidate.
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      0,    0,     0, 0);
        addVec(1, 0, 0, 0, 0, 0,            1, 0,      BYP,  0,     0, 4);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      1,    0,     1, 4);
        addVec(1, 0, 0, 0, 0, 0,            1, 4,      1,    0,     1, 8);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      1,    0,     2, 8);
        addVec(1, 0, 0, 0, 0, 0,            1, 8,      1,    0,     2, 12);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      1,    0,     3, 12);
        addVec(1, 0, 0, 0, 0, 0,            1, 12,     1,    0,     3, 16);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      1,    0,     4, 16);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      1,    0,     4, 16);
        addVec(0, 1, 0, 0, 0, 0,            0, 0,      1,    0,     4, 16);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      1,    4,     3, 16);
        addVec(0, 0, 0, 0, 0, 0,            1, 16,     1,    4,     3, 16);
        addVec(0, 0, 1, 64'h100, 0, 0,      1, 16,     1,    4,     3, 64'h100);
        addVec(0, 0, 0, 0, 0, 0,            1, 16,     0,    0,     0, 64'h100);
        addVec(1, 0, 0, 0, 0, 0,            1, 16,     0,    0,     0, 64'h100);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      0,    0,     0, 64'h100);
        addVec(0, 0, 1, 64'h100, 1, 64'h200, 1, 64'h100, 0,  0,     0, 64'h200);
        addVec(1, 0, 0, 0, 0, 0,            1, 64'h100, 0,   0,     0, 64'h200);
        addVec(0, 0, 0, 0, 0, 0,            0, 0,      0,    0,     0, 64'h200);
        addVec(1, 1, 0, 0, 0, 0,            1, 64'h200, BYP, 64'h200, 0, 64'h204);
        addVec(0, 1, 0, 0, 0, 0,            0, 0,      !BYP, 64'h200, BYP ? 0 : 1, 64'h204);
        addVec(0, 0, 0, 0, 0, 0,            1, 64'h204, 0,   0,     0, 64'h204);

        clk        = 1'b0;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dec_ready  = 1'b0;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;
        EProc_F    = 1'b0;
        EVAddr_F   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset.req", 64'(imem_req), 64'd0);
        check("reset.valid", 64'(dec_valid), 64'd0);
        check("reset.count", 64'(fq_count), 64'd0);
        check("reset.dpc", dec_pc, 64'd0);
        check("reset.instr", 64'(dec_instr), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            runCycle($sformatf("vec%0d", i), 1'b0, vecs[i].ack, vecs[i].rdy, vecs[i].ps, vecs[i].pb,
                     vecs[i].ep, vecs[i].ev, vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid,
                     vecs[i].eDpc, vecs[i].eCnt, vecs[i].eNext);
        end

        // PC wrap-around at the top of the address space.
        runCycle("wrap0", 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 64'h204, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        runCycle("wrap1", 0, 1, 0, 0, 0, 0, 0, 1, 64'h204, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        runCycle("wrap2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        runCycle("wrap3", 0, 1, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, BYP, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0);
        runCycle("wrap4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0);
        runCycle("wrap5", 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0);

        // Reset while a request is outstanding, with its ack arriving in the reset cycle.
        @(negedge clk);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        runCycle("rstmid", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
        check("rstmid.dpc", dec_pc, 64'd0);
        check("rstmid.instr", 64'(dec_instr), 64'd0);

        // Random traffic against a transaction-level model.
        mPc    = '0;
        mAddr  = '0;
        mBusy  = 1'b0;
        mStale = 1'b0;
        lat    = -1;
        mQ.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ps = ($urandom_range(0, 99) < 6);
            ep = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 2))
                0:       pb = {$urandom(), $urandom()};
                1:       pb = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: pb = 64'($urandom_range(0, 255)) << 2;
            endcase
            ev = ($urandom_range(0, 1) == 0) ? 64'h200 : (64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7)));
            r  = ($urandom_range(0, 99) < 60);
            a  = 1'b0;
            if (mBusy) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                a = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                lat = -1;
            end
            if (a) lat = -1;

            applyStimulus(0, a, r, ps, pb, ep, ev);

            redirect   = ps | ep;
            tgt        = ep ? ev : pb;
            sizeBefore = mQ.size();
            accept     = mBusy && !mStale && a && !redirect;
            bypassHit  = BYP && accept && (sizeBefore == 0);
            take       = bypassHit && r;
            nextPc     = redirect ? tgt : (accept ? mPc + 64'd4 : mPc);
            eValid     = (sizeBefore > 0) || bypassHit;
            eDpc       = (sizeBefore > 0) ? mQ[0].pc : mPc;

            check($sformatf("rnd%0d.ackLegal", cyc), 64'(a && !imem_req), 64'd0);
            checkOutput($sformatf("rnd%0d", cyc), mBusy, mAddr, eValid, eDpc, sizeBefore, nextPc);

            if (mBusy) begin
                if (a) begin
                    mBusy  = 1'b0;
                    mStale = 1'b0;
                end else if (redirect) begin
                    mStale = 1'b1;
                end
            end else if (!redirect && sizeBefore < DEPTH) begin
                mBusy  = 1'b1;
                mStale = 1'b0;
                mAddr  = mPc;
            end
            if (redirect) begin
                mQ.delete();
            end else begin
                if (r && mQ.size() > 0) void'(mQ.pop_front());
                if (accept && !take) mQ.push_back('{mPc, memData(mPc)});
            end
            mPc = nextPc;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
